video_ce_gen: RTL and testbench

Multi-channel fractional clock-enable generator for the video/audio clock tree. It derives any number of pixel- or sample-rate enables from one PLL output clock using per-channel phase accumulators. Each channel's ratio and phase can be reprogrammed at run time; changes take effect only on a pulse boundary, so no enable is ever split or duplicated. A `locked` output combines the upstream PLL lock with a settle interval after every retune, so downstream cores can gate on one signal.

---
 rtl/video_ce_gen.sv | 137 +++++++++++++
 tb/tb_video_ce_gen.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/video_ce_gen.sv
// video_ce_gen: multi-channel fractional clock-enable generator.
// Each channel runs a phase accumulator; the carry out of acc + inc is the
// enable pulse. Retunes are held in one shared pending slot and applied only
// on a pulse boundary (or at once if the channel is disabled). The locked
// output combines the synchronised upstream lock with a settle interval.
module video_ce_gen #(
   parameter int unsigned CHANNELS    = 2,
   parameter int unsigned ACC_W       = 32,
   parameter int unsigned LOCK_CYCLES = 1024,
   localparam int unsigned CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                refclk,
   input  logic                rst,
   input  logic                ext_locked,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_W-1:0]     cfg_chan,
   input  logic [ACC_W-1:0]    cfg_inc,
   input  logic [ACC_W-1:0]    cfg_phase,
   output logic [CHANNELS-1:0] ce_out,
   output logic                locked
);

   localparam int unsigned CNT_W = $clog2(LOCK_CYCLES + 1);

   logic [ACC_W-1:0]    acc_q [CHANNELS];
   logic [ACC_W-1:0]    acc_d [CHANNELS];
   logic [ACC_W-1:0]    inc_q [CHANNELS];
   logic [ACC_W-1:0]    inc_d [CHANNELS];
   logic [ACC_W:0]      sum_c [CHANNELS];
   logic [CHANNELS-1:0] ce_q, ce_d;

   logic                sync_meta_q, sync_q;

   logic                pend_q, pend_d;
   logic [CH_W-1:0]     pend_chan_q;
   logic [ACC_W-1:0]    pend_inc_q, pend_phase_q;
   logic                ready_q, ready_d;

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                locked_q, locked_d;

   logic                xfer_c, chan_ok_c, apply_c, clr_c;

   assign cfg_ready = ready_q;
   assign ce_out    = ce_q;
   assign locked    = locked_q;

   assign xfer_c    = cfg_valid && ready_q;
   assign chan_ok_c = (32'(pend_chan_q) < CHANNELS);

   // Per-channel accumulate with carry in ACC_W+1 bits.
   always_comb begin
      for (int n = 0; n < CHANNELS; n++) begin
         sum_c[n] = {1'b0, acc_q[n]} + {1'b0, inc_q[n]};
      end
   end

   // Next-state for accumulators, pending slot, handshake and lock counter.
   always_comb begin
      apply_c  = 1'b0;
      pend_d   = pend_q;
      ready_d  = ready_q;
      ce_d     = '0;
      for (int n = 0; n < CHANNELS; n++) begin
         acc_d[n] = sum_c[n][ACC_W-1:0];
         inc_d[n] = inc_q[n];
         ce_d[n]  = sum_c[n][ACC_W];
         // Apply on a pulse boundary, or immediately when the channel is idle.
         if (pend_q && chan_ok_c && (CH_W'(n) == pend_chan_q) &&
             ((inc_q[n] == '0) || sum_c[n][ACC_W])) begin
            acc_d[n] = pend_phase_q;
            inc_d[n] = pend_inc_q;
            apply_c  = 1'b1;
         end
      end

      // Slot empties on apply, or on the first pending cycle if out of range.
      if (pend_q && (apply_c || !chan_ok_c)) begin
         pend_d  = 1'b0;
         ready_d = 1'b1;
      end
      if (xfer_c) begin
         pend_d  = 1'b1;
         ready_d = 1'b0;
      end

      // A dropped config does not disturb lock; a valid pending one does.
      clr_c = !sync_q || (pend_q && chan_ok_c);
      if (clr_c) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(LOCK_CYCLES)) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      locked_d = !clr_c && (cnt_q == CNT_W'(LOCK_CYCLES));
   end

   // State registers with asynchronous reset.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < CHANNELS; n++) begin
            acc_q[n] <= '0;
            inc_q[n] <= '0;
         end
         ce_q         <= '0;
         sync_meta_q  <= 1'b0;
         sync_q       <= 1'b0;
         pend_q       <= 1'b0;
         pend_chan_q  <= '0;
         pend_inc_q   <= '0;
         pend_phase_q <= '0;
         ready_q      <= 1'b1;
         cnt_q        <= '0;
         locked_q     <= 1'b0;
      end else begin
         for (int n = 0; n < CHANNELS; n++) begin
            acc_q[n] <= acc_d[n];
            inc_q[n] <= inc_d[n];
         end
         ce_q        <= ce_d;
         sync_meta_q <= ext_locked;
         sync_q      <= sync_meta_q;
         pend_q      <= pend_d;
         ready_q     <= ready_d;
         cnt_q       <= cnt_d;
         locked_q    <= locked_d;
         if (xfer_c) begin
            pend_chan_q  <= cfg_chan;
            pend_inc_q   <= cfg_inc;
            pend_phase_q <= cfg_phase;
         end
      end
   end

endmodule

// File: tb/tb_video_ce_gen.sv
// Directed bench for video_ce_gen with a ce_out scoreboard queue.
// A second instance with three channels exercises the out-of-range drop path.
module tb_video_ce_gen;

   logic       refclk = 1'b0;
   logic       rst;
   logic       ext_locked;
   logic       cfg_valid, cfg_ready;
   logic [0:0] cfg_chan;
   logic [7:0] cfg_inc, cfg_phase;
   logic [1:0] ce_out;
   logic       locked;

   logic       cfg_valid3, cfg_ready3;
   logic [1:0] cfg_chan3;
   logic [2:0] ce_out3;
   logic       locked3;

   int         checks, errors, cyc, pulses;
   logic [1:0] exp_q [$];

   always #5 refclk = ~refclk;

   video_ce_gen #(.CHANNELS(2), .ACC_W(8), .LOCK_CYCLES(16)) u_dut (
      .refclk(refclk), .rst(rst), .ext_locked(ext_locked),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
      .cfg_inc(cfg_inc), .cfg_phase(cfg_phase), .ce_out(ce_out), .locked(locked)
   );

   video_ce_gen #(.CHANNELS(3), .ACC_W(8), .LOCK_CYCLES(16)) u_dut3 (
      .refclk(refclk), .rst(rst), .ext_locked(ext_locked),
      .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3), .cfg_chan(cfg_chan3),
      .cfg_inc(cfg_inc), .cfg_phase(cfg_phase), .ce_out(ce_out3), .locked(locked3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock; pops and compares the next expected ce_out if one is queued.
   task automatic tick();
      logic [1:0] e;
      @(posedge refclk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("ce_out", 32'(ce_out), 32'(e));
      end
   endtask

   task automatic push_seq(input int n, input logic [63:0] c0, input logic [63:0] c1);
      for (int i = 0; i < n; i++) exp_q.push_back({c1[i], c0[i]});
   endtask

   // Steady state after the last retune: ch0 pulses on even cycles, ch1 on odd.
   task automatic run_to(input int n);
      int e;
      for (int i = cyc + 1; i <= n; i++) begin
         e = i;
         exp_q.push_back({e[0], ~e[0]});
      end
      while (cyc < n) tick();
   endtask

   task automatic cfg_write(input logic [0:0] ch, input logic [7:0] inc, input logic [7:0] ph);
      check("ready_before_xfer", 32'(cfg_ready), 32'd1);
      cfg_valid = 1'b1;
      cfg_chan  = ch;
      cfg_inc   = inc;
      cfg_phase = ph;
      tick();
      cfg_valid = 1'b0;
      check("ready_after_xfer", 32'(cfg_ready), 32'd0);
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0; pulses = 0;
      rst = 1'b1; ext_locked = 1'b1;
      cfg_valid = 1'b0; cfg_chan = '0; cfg_inc = '0; cfg_phase = '0;
      cfg_valid3 = 1'b0; cfg_chan3 = '0;
      repeat (3) @(negedge refclk);
      check("rst_ce_out", 32'(ce_out), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_ready", 32'(cfg_ready), 32'd1);
      rst = 1'b0;

      // Enable ch0 from disabled: applies at cycle 2, pulses on even cycles from 4.
      push_seq(10, 64'h2A8, 64'h0);
      cfg_write(1'b0, 8'd128, 8'd0);
      tick();
      check("ready_after_apply_a", 32'(cfg_ready), 32'd1);
      repeat (8) tick();

      // ch1 with phase 128: applies at 12, pulses on odd cycles from 13.
      push_seq(8, 64'hAA, 64'h54);
      cfg_write(1'b1, 8'd128, 8'd128);
      repeat (7) tick();

      // ch0 -> inc 192: boundary apply at 20, then 3 pulses per 4 cycles.
      push_seq(2, 64'h2, 64'h1);
      for (int k = 0; k < 256; k++) exp_q.push_back({(k % 2) == 0, (k % 4) != 0});
      cfg_write(1'b0, 8'd192, 8'd0);
      tick();
      check("ready_after_apply_c", 32'(cfg_ready), 32'd1);
      for (int k = 0; k < 256; k++) begin
         tick();
         if (ce_out[0]) pulses++;
      end
      check("ratio_192_pulses", 32'(pulses), 32'd192);

      // ch0 -> inc 64 then back to 128; each retune lands on a pulse.
      push_seq(14, 64'h2A22, 64'h1555);
      cfg_write(1'b0, 8'd64, 8'd0);
      check("locked_before_retune", 32'(locked), 32'd1);
      tick();
      check("locked_after_xfer", 32'(locked), 32'd0);
      check("ready_after_apply_d", 32'(cfg_ready), 32'd1);
      repeat (4) tick();
      cfg_write(1'b0, 8'd128, 8'd0);
      tick();
      check("ready_pending_1", 32'(cfg_ready), 32'd0);
      tick();
      check("ready_pending_2", 32'(cfg_ready), 32'd0);
      tick();
      check("ready_after_apply_e", 32'(cfg_ready), 32'd1);
      repeat (4) tick();

      // Lock rises 17 cycles after the apply at 286.
      run_to(302);
      check("locked_pre_rise", 32'(locked), 32'd0);
      run_to(303);
      check("locked_rise", 32'(locked), 32'd1);
      ext_locked = 1'b0;
      run_to(305);
      check("locked_sync_delay", 32'(locked), 32'd1);
      run_to(306);
      check("locked_fall_ext", 32'(locked), 32'd0);
      run_to(309);
      ext_locked = 1'b1;
      run_to(327);
      check("locked_pre_rerise", 32'(locked), 32'd0);
      run_to(328);
      check("locked_rerise", 32'(locked), 32'd1);
      check("locked3_rerise", 32'(locked3), 32'd1);

      // Out-of-range channel on the 3-channel instance is dropped silently.
      check("ready3_before", 32'(cfg_ready3), 32'd1);
      cfg_valid3 = 1'b1;
      cfg_chan3  = 2'd3;
      cfg_inc    = 8'd64;
      cfg_phase  = 8'd0;
      run_to(329);
      cfg_valid3 = 1'b0;
      check("ready3_after_xfer", 32'(cfg_ready3), 32'd0);
      check("locked3_xfer", 32'(locked3), 32'd1);
      run_to(330);
      check("ready3_after_drop", 32'(cfg_ready3), 32'd1);
      check("locked3_drop", 32'(locked3), 32'd1);
      run_to(331);
      check("locked3_after", 32'(locked3), 32'd1);
      check("ce3_idle", 32'(ce_out3), 32'd0);

      // Async reset while a retune of ch1 is pending.
      push_seq(1, 64'h1, 64'h0);
      cfg_write(1'b1, 8'd64, 8'd192);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      rst = 1'b1;
      #1;
      check("midrst_ce_out", 32'(ce_out), 32'd0);
      check("midrst_locked", 32'(locked), 32'd0);
      check("midrst_ready", 32'(cfg_ready), 32'd1);
      repeat (2) @(negedge refclk);
      rst = 1'b0;
      push_seq(8, 64'h0, 64'h0);
      repeat (8) tick();
      check("post_rst_ready", 32'(cfg_ready), 32'd1);
      check("post_rst_locked", 32'(locked), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
